risc_fetch_ctrl: RTL and testbench
==================================

# risc_fetch_ctrl

Fetch-stage controller that sequences the program-counter register and the instruction-memory port of the 5-stage pipeline. It generates the PC enable/disable and next-PC value, runs a request/acknowledge handshake with a variable-latency instruction memory, holds fetched instructions across hazard-unit stalls, and squashes in-flight fetches when a branch or jump redirects from EX. It sits between the PC register, the instruction memory, the hazard unit and the IF/ID pipeline register.

## Interface

- MEM_TIMEOUT, default 255: number of consecutive un-acked request cycles after which fetch_err sets.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- PCF  in  32  current PC from the PC register
- PCPlus4F  in  32  PCF + 4 from the PC register
- PCTargetE  in  32  branch/jump target from EX
- PCSrcE  in  1  redirect taken in EX this cycle
- StallF  in  1  hazard-unit fetch stall
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address, equals PCF
- imem_ack  in  1  single-cycle acknowledge, data valid same cycle
- imem_rdata  in  32  instruction word
- PCFp  out  32  next-PC value to the PC register
- pc_dis  out  1  PC register hold (1 = hold)
- InstrF  out  32  instruction toward IF/ID; 32'h00000013 (NOP) when invalid
- InstrValidF  out  1  InstrF is a live instruction this cycle
- FlushD  out  1  flush IF/ID
- fetch_err  out  1  sticky memory-timeout flag

## Operation

- States: IDLE, REQ, HOLD, DISCARD (enum in package).
- IDLE: entered on reset; imem_req=0, pc_dis=1; next cycle -> REQ. PCSrcE in IDLE: PCFp=PCTargetE, pc_dis=0, -> REQ.
- REQ: imem_req=1, imem_addr=PCF stable until ack (pc_dis=1 while waiting).
  - ack, !PCSrcE, !StallF: InstrF=imem_rdata, InstrValidF=1, PCFp=PCPlus4F, pc_dis=0, stay REQ.
  - ack, !PCSrcE, StallF: capture imem_rdata into hold register, pc_dis=1, -> HOLD.
  - ack, PCSrcE: drop word, PCFp=PCTargetE, pc_dis=0, stay REQ.
  - no ack, PCSrcE: latch PCTargetE into redirect register, -> DISCARD (PC must not move while request outstanding).
- HOLD: imem_req=0, InstrF=hold register, InstrValidF=1; !StallF: PCFp=PCPlus4F, pc_dis=0, -> REQ; PCSrcE: drop held word, PCFp=PCTargetE, pc_dis=0, -> REQ.
- DISCARD: imem_req=1 at old PCF, InstrValidF=0; on ack: PCFp=redirect register, pc_dis=0, -> REQ. Second PCSrcE in DISCARD overwrites redirect register.
- Priority: PCSrcE > StallF everywhere.
- FlushD = PCSrcE (combinational).
- Timeout counter: increments each cycle imem_req=1 and !imem_ack, clears on ack; reaching MEM_TIMEOUT sets fetch_err, cleared only by rst. Counter saturates, no wrap. Fetch continues waiting.
- PCFp defaults to PCPlus4F whenever pc_dis=1.

## Timing

- Reset (async assert): state=IDLE, imem_req=0, pc_dis=1, InstrValidF=0, InstrF=NOP, hold/redirect registers=0, counter=0, fetch_err=0. Reset mid-request abandons the transaction; memory must tolerate req dropping.
- First request: cycle 1 after rst deassert.
- Zero-wait memory (ack in request cycle): one instruction per cycle, PC advances every cycle.
- Redirect latency: target issued on imem_addr the cycle after PCSrcE (REQ/HOLD/IDLE), or the cycle after the outstanding ack (DISCARD).
- Outputs InstrF/InstrValidF/PCFp/pc_dis/imem_req/FlushD are combinational from state, registers and inputs; no input-to-output path through imem_rdata except InstrF.

## Structure

- Package risc_fetch_pkg: fetch_state_t enum, NOP_INSTR = 32'h00000013, counter width derived from MEM_TIMEOUT ($clog2).
- Single module, no sub-module; hold register, redirect register and timeout counter inline.

## Test plan

- Reset then zero-wait memory returning 0x00A00093, 0x00108113: imem_addr 0x0, 0x4, 0x8 on consecutive cycles, InstrValidF=1 each ack.
- 3-cycle ack latency at 0x0: pc_dis=1 and imem_addr=0x0 for 3 cycles, advance to 0x4 on ack cycle.
- StallF=1 for 2 cycles coincident with ack of 0x00A00093: HOLD, InstrF stays 0x00A00093, no new request, advances after StallF drops.
- PCSrcE with PCTargetE=0x40 while request at 0x8 un-acked: DISCARD, 0x8 word dropped (InstrValidF=0), next request at 0x40, FlushD=1 for 1 cycle.
- PCSrcE and StallF together in HOLD: held word dropped, next imem_addr=PCTargetE.
- MEM_TIMEOUT=4, ack withheld 10 cycles: fetch_err sets after 4th un-acked cycle, stays set after ack, clears only on rst.

Source files
------------

// File: rtl/risc_fetch_pkg.sv
// Shared types and constants for the fetch-stage controller.
package risc_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StHold    = 2'd2,
    StDiscard = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Wide enough to hold the timeout value itself, since the counter saturates there.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/risc_fetch_ctrl.sv
// Fetch-stage controller: PC sequencing, instruction-memory handshake,
// stall holding and redirect squashing for the 5-stage pipeline.
module risc_fetch_ctrl
  import risc_fetch_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  input  logic [31:0] PCTargetE,
  input  logic        PCSrcE,
  input  logic        StallF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCFp,
  output logic        pc_dis,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic        FlushD,
  output logic        fetch_err
);

  localparam int unsigned   CntW   = cnt_width(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

  fetch_state_t    r_state, w_state_nxt;
  logic [31:0]     r_hold, r_redirect;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_err;
  logic            w_hold_ld, w_redir_ld, w_err_set;

  assign imem_addr = PCF;
  assign FlushD    = PCSrcE;
  assign fetch_err = r_err;

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    pc_dis      = 1'b1;
    PCFp        = PCPlus4F;
    InstrF      = NOP_INSTR;
    InstrValidF = 1'b0;
    w_hold_ld   = 1'b0;
    w_redir_ld  = 1'b0;
    case (r_state)
      StIdle: begin
        w_state_nxt = StReq;
        if (PCSrcE) begin
          PCFp   = PCTargetE;
          pc_dis = 1'b0;
        end
      end
      StReq: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (PCSrcE) begin
            PCFp   = PCTargetE;
            pc_dis = 1'b0;
          end else begin
            InstrF      = imem_rdata;
            InstrValidF = 1'b1;
            if (StallF) begin
              w_hold_ld   = 1'b1;
              w_state_nxt = StHold;
            end else begin
              pc_dis = 1'b0;
            end
          end
        end else if (PCSrcE) begin
          // PC must stay on the outstanding address until the memory acks.
          w_redir_ld  = 1'b1;
          w_state_nxt = StDiscard;
        end
      end
      StHold: begin
        if (PCSrcE) begin
          PCFp        = PCTargetE;
          pc_dis      = 1'b0;
          w_state_nxt = StReq;
        end else begin
          InstrF      = r_hold;
          InstrValidF = 1'b1;
          if (!StallF) begin
            pc_dis      = 1'b0;
            w_state_nxt = StReq;
          end
        end
      end
      StDiscard: begin
        imem_req   = 1'b1;
        w_redir_ld = PCSrcE;
        if (imem_ack) begin
          PCFp        = PCSrcE ? PCTargetE : r_redirect;
          pc_dis      = 1'b0;
          w_state_nxt = StReq;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (imem_ack) begin
      w_cnt_nxt = '0;
    end else if (imem_req && (r_cnt != CntMax)) begin
      w_cnt_nxt = r_cnt + CntW'(1);
    end
  end

  assign w_err_set = imem_req && !imem_ack && (w_cnt_nxt == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_hold     <= '0;
      r_redirect <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_ld) begin
        r_hold <= imem_rdata;
      end
      if (w_redir_ld) begin
        r_redirect <= PCTargetE;
      end
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_err_set;
    end
  end

endmodule

// File: tb/tb_risc_fetch_ctrl.sv
// Bench for risc_fetch_ctrl: directed scenarios plus a randomized run checked
// against a program-order instruction-stream model through a scoreboard queue.
module tb_risc_fetch_ctrl;
  import risc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCPlus4F, PCTargetE;
  logic        PCSrcE, StallF;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCFp, InstrF;
  logic        pc_dis, InstrValidF, FlushD, fetch_err;

  always #5 clk = ~clk;
  assign PCPlus4F = PCF + 32'd4;

  risc_fetch_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .PCTargetE  (PCTargetE),
    .PCSrcE     (PCSrcE),
    .StallF     (StallF),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .PCFp       (PCFp),
    .pc_dis     (pc_dis),
    .InstrF     (InstrF),
    .InstrValidF(InstrValidF),
    .FlushD     (FlushD),
    .fetch_err  (fetch_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_pop  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  int          k_lat, k_p_stall, k_p_redir, r_wait;
  bit          f_stall, f_redir, rel_rst;
  logic [31:0] f_target, r_nxt;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    if (a == 32'h4) return 32'h00108113;
    return a * 32'h9E3779B1 + 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: words in program order from the latest redirect target.
  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(mem_word(model_pc));
      model_pc += 32'd4;
    end
  endfunction

  function automatic void redirect_model(input logic [31:0] t);
    exp_q.delete();
    model_pc = t;
    refill();
  endfunction

  // One clock: update bench PC register, drive hazard/redirect inputs and the
  // memory response, then sample at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rel_rst) begin
      rst     = 1'b0;
      rel_rst = 1'b0;
    end
    PCF    = r_nxt;
    StallF = f_stall || (int'($urandom_range(0, 99)) < k_p_stall);
    PCSrcE = f_redir || (int'($urandom_range(0, 99)) < k_p_redir);
    if (PCSrcE) begin
      PCTargetE = f_redir ? f_target : (32'($urandom_range(0, 1023)) << 2);
      redirect_model(PCTargetE);
    end
    refill();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (imem_req) begin
      if (r_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(PCF);
        r_wait     = (k_lat < 0) ? int'($urandom_range(0, 3)) : k_lat;
      end else begin
        r_wait--;
      end
    end
    @(negedge clk);
    r_nxt = pc_dis ? PCF : PCFp;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    PCSrcE     = 1'b0;
    StallF     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    PCTargetE  = '0;
    PCF        = '0;
    r_nxt      = '0;
    f_stall    = 1'b0;
    f_redir    = 1'b0;
    r_wait     = (k_lat < 0) ? 0 : k_lat;
    redirect_model(32'h0);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc_dis", pc_dis, 1);
    chk("rst_valid", InstrValidF, 0);
    chk("rst_instr", InstrF, NOP_INSTR);
    chk("rst_err", fetch_err, 0);
    rel_rst = 1'b1;
    cyc();
    chk("idle_req", imem_req, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      chk("flushd", FlushD, PCSrcE);
      if (prev_req && !prev_ack) begin
        chk("req_held", imem_req, 1);
        chk("addr_held", imem_addr, prev_addr);
      end
      if (PCSrcE) begin
        chk("redir_drop", InstrValidF, 0);
      end else if (InstrValidF) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL instr: got %h expected none at %0t", InstrF, $time);
        end else begin
          chk("instr", InstrF, exp_q[0]);
          if (!StallF) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rel_rst = 1'b0; k_p_stall = 0; k_p_redir = 0; f_target = '0;
    PCF = '0; PCTargetE = '0; PCSrcE = 1'b0; StallF = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; f_stall = 1'b0; f_redir = 1'b0; r_nxt = '0;

    // Zero-wait memory: one instruction per cycle.
    k_lat = 0;
    do_reset();
    cyc();
    chk("zw_addr0", imem_addr, 32'h0);
    chk("zw_valid0", InstrValidF, 1);
    chk("zw_instr0", InstrF, 32'h00A00093);
    chk("zw_pc_dis0", pc_dis, 0);
    cyc();
    chk("zw_addr1", imem_addr, 32'h4);
    chk("zw_instr1", InstrF, 32'h00108113);
    cyc();
    chk("zw_addr2", imem_addr, 32'h8);
    chk("zw_valid2", InstrValidF, 1);

    // Three-cycle ack latency.
    k_lat = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lat_pc_dis", pc_dis, 1);
      chk("lat_addr", imem_addr, 32'h0);
      chk("lat_valid", InstrValidF, 0);
    end
    cyc();
    chk("lat_ack_pc_dis", pc_dis, 0);
    chk("lat_ack_pcfp", PCFp, 32'h4);
    cyc();
    chk("lat_next_addr", imem_addr, 32'h4);

    // Stall on ack -> hold, then stall plus redirect in hold.
    k_lat = 0;
    do_reset();
    f_stall = 1'b1;
    cyc();
    chk("st_ack_valid", InstrValidF, 1);
    chk("st_ack_pc_dis", pc_dis, 1);
    cyc();
    chk("st_hold_req", imem_req, 0);
    chk("st_hold_instr", InstrF, 32'h00A00093);
    chk("st_hold_pc_dis", pc_dis, 1);
    f_stall = 1'b0;
    cyc();
    chk("st_rel_pc_dis", pc_dis, 0);
    chk("st_rel_pcfp", PCFp, 32'h4);
    f_stall = 1'b1;
    cyc();
    chk("st_addr4", imem_addr, 32'h4);
    f_redir  = 1'b1;
    f_target = 32'h40;
    cyc();
    chk("hr_valid", InstrValidF, 0);
    chk("hr_pc_dis", pc_dis, 0);
    chk("hr_pcfp", PCFp, 32'h40);
    f_redir = 1'b0;
    f_stall = 1'b0;
    cyc();
    chk("hr_addr", imem_addr, 32'h40);
    chk("hr_req", imem_req, 1);

    // Redirect while the request at 0x8 is outstanding.
    k_lat = 0;
    do_reset();
    cyc();
    k_lat = 3;
    cyc();
    cyc();
    f_redir  = 1'b1;
    f_target = 32'h40;
    cyc();
    chk("dc_pc_dis", pc_dis, 1);
    chk("dc_addr", imem_addr, 32'h8);
    f_redir = 1'b0;
    k_lat   = 0;
    cyc();
    chk("dc_flush_one", FlushD, 0);
    chk("dc_wait_addr", imem_addr, 32'h8);
    cyc();
    chk("dc_ack_valid", InstrValidF, 0);
    chk("dc_ack_pcfp", PCFp, 32'h40);
    chk("dc_ack_pc_dis", pc_dis, 0);
    cyc();
    chk("dc_new_addr", imem_addr, 32'h40);

    // Randomized run against the stream model.
    k_lat = -1;
    k_p_stall = 25;
    k_p_redir = 8;
    do_reset();
    for (int i = 0; i < 3000; i++) cyc();
    chk("rand_no_err", fetch_err, 0);
    chk("rand_progress", 32'(n_pop >= 200), 1);
    k_p_stall = 0;
    k_p_redir = 0;

    // Timeout: ack withheld 10 cycles with MEM_TIMEOUT=4.
    k_lat = 0;
    do_reset();
    r_wait = 10;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("to_err", fetch_err, (k >= 5) ? 1 : 0);
    end
    cyc();
    chk("to_ack", imem_ack, 1);
    chk("to_err_after_ack", fetch_err, 1);
    cyc();
    chk("to_err_sticky", fetch_err, 1);
    do_reset();
    chk("to_err_cleared", fetch_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
